// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed 8-digit 7-segment display driver.
//
// The 32-bit hex value (nibble i -> digit i) and the per-digit decimal-point
// mask are copied into a shadow register once per frame, at the last cycle of
// digit 7's slot. Changes in between therefore never tear a frame.
//
// Each digit owns a slot of SCAN_DIV clock cycles. The first BLANK_CYC cycles
// of every slot drive all anodes off. This gives the previous digit's segments
// time to discharge before the next anode turns on, which prevents ghosting.
//
// All display outputs are registered. They show the scan position and shadow
// contents of the previous cycle, so there is one cycle of latency.
//
// Build option:
//   SEG7_LZB_EN  - leading-zero blanking. Digit i (i >= 1) stays dark when
//                  nibbles i..7 of the shadow value are all zero and its
//                  decimal point is off. Digit 0 is always lit.
//                  When the macro is undefined, every digit is lit, so
//                  leading zeros are shown as "0".
//
// Observability:
//   There is no FSM. The scan position is the pair (cnt_q, idx_q):
//     cnt_q - cycle within the current digit slot, 0..SCAN_DIV-1
//     idx_q - digit currently being scanned, 0..7
//
// Handshake:
//   frame_tick is a strobe with no ready. It is high for exactly one cycle,
//   the cycle right after a new frame value has been latched.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_data,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_tick
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int              CNT_W    = (SCAN_DIV >= 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_V  = CNT_W'(BLANK_CYC);

    // Values driven while a digit is dark
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // ------------------------------------------------------------------------
    // Parameter sanity checks. These are reported at elaboration; there is
    // no hardware checking.
    // ------------------------------------------------------------------------
    generate
        if (SCAN_DIV < 2) begin : g_chk_scan_div
            $error("seg7_scan_driver: SCAN_DIV (%0d) must be >= 2", SCAN_DIV);
        end
        if ((BLANK_CYC < 0) || (BLANK_CYC >= SCAN_DIV)) begin : g_chk_blank_cyc
            $error("seg7_scan_driver: BLANK_CYC (%0d) must be in 0..SCAN_DIV-1", BLANK_CYC);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Hex nibble to active-low segments, bit order {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [2:0]       idx_q,         idx_d;
    logic [31:0]      shadow_data_q, shadow_data_d;
    logic [7:0]       shadow_dp_q,   shadow_dp_d;
    logic             frame_tick_q,  frame_tick_d;
    logic [7:0]       an_q,          an_d;
    logic [6:0]       seg_q,         seg_d;
    logic             dp_q,          dp_d;

    logic             slot_end;
    logic             frame_end;
    logic             blank_slot;
    logic             lzb_blank;
    logic [3:0]       cur_nib;

    // ------------------------------------------------------------------------
    // Scan position: cnt walks through one slot, idx advances when it wraps
    // ------------------------------------------------------------------------
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == 3'd7);
        cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
    end

    // Scan counter registers; reset restarts the scan at digit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame latch: capture the inputs only on the last cycle of a frame
    // ------------------------------------------------------------------------
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        frame_tick_d  = frame_end;
        if (frame_end) begin
            shadow_data_d = seg_data;
            shadow_dp_d   = dp_mask;
        end
    end

    // Shadow registers and frame strobe; the first frame after reset shows zero
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    // ------------------------------------------------------------------------
    // Anti-ghosting gap at the start of each slot. With BLANK_CYC = 0 there
    // is no gap, so no comparison is built.
    // ------------------------------------------------------------------------
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign blank_slot = 1'b0;
        end else begin : g_blank
            assign blank_slot = (cnt_q < BLANK_V);
        end
    endgenerate

    // Nibble belonging to the digit currently being scanned
    assign cur_nib = shadow_data_q[{idx_q, 2'b00} +: 4];

    // ------------------------------------------------------------------------
    // Leading-zero blanking
    // ------------------------------------------------------------------------
`ifdef SEG7_LZB_EN
    logic [7:0] nz_above;

    // nz_above[i] is set when any nibble i..7 of the shadow value is non-zero
    always_comb begin
        nz_above = '0;
        for (int i = 0; i < 8; i++) begin
            nz_above[i] = |(shadow_data_q >> (4 * i));
        end
    end

    assign lzb_blank = (idx_q != 3'd0) && !nz_above[idx_q] && !shadow_dp_q[idx_q];
`else
    assign lzb_blank = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next display value for the current scan position
    // ------------------------------------------------------------------------
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!blank_slot && !lzb_blank) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = hex_to_seg(cur_nib);
            dp_d  = ~shadow_dp_q[idx_q];
        end
    end

    // Registered outputs; reset turns the display fully dark
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Two instances share the stimulus:
//   dut1: SCAN_DIV=4, BLANK_CYC=1 (main configuration)
//   dut2: SCAN_DIV=2, BLANK_CYC=0 (no blanking gap)
//
// Every clock, the driver pushes the expected {an_n, seg_n, dp_n, frame_tick}
// of each instance into its queue. A monitor on the falling edge pops and
// compares. The expected values come from the hand-written decode table and
// from the slot timing seen from reset. The build option SEG7_LZB_EN is
// honoured.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] seg_data;
    logic [7:0]  dp_mask;

    logic [7:0]  an1_n,  an2_n;
    logic [6:0]  seg1_n, seg2_n;
    logic        dp1_n,  dp2_n;
    logic        tick1,  tick2;

    seg7_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .dp_mask    (dp_mask),
        .an_n       (an1_n),
        .seg_n      (seg1_n),
        .dp_n       (dp1_n),
        .frame_tick (tick1)
    );

    seg7_scan_driver #(.SCAN_DIV(2), .BLANK_CYC(0)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .dp_mask    (dp_mask),
        .an_n       (an2_n),
        .seg_n      (seg2_n),
        .dp_n       (dp2_n),
        .frame_tick (tick2)
    );

    // Hand-computed active-low segment codes {g..a} for nibbles 0..F
    localparam logic [6:0] DEC [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Expected value for a dark display with no strobe
    localparam logic [16:0] EXP_DARK = {8'hFF, 7'h7F, 1'b1, 1'b0};

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    logic [16:0] exp1_q[$];
    logic [16:0] exp2_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Edges since the last reset edge, plus what the bench expects each
    // instance to have latched so far
    int          k1, k2;
    logic [31:0] sh1, sh2;
    logic [7:0]  shdp1, shdp2;

    // Expected outputs after the k-th edge following reset. The outputs
    // reflect the scan position after edge k-1.
    function automatic logic [16:0] expect_out(input int k, input int sd, input int bc,
                                               input logic [31:0] sh, input logic [7:0] shdp);
        int         m, cnt, idx;
        logic [7:0] an;
        logic [6:0] sg;
        logic       dp, tk;
        logic [3:0] nib;
        m   = k - 1;
        cnt = m % sd;
        idx = (m / sd) % 8;
        tk  = ((k % (8 * sd)) == 0);
        an  = 8'hFF;
        sg  = 7'h7F;
        dp  = 1'b1;
        if (cnt >= bc) begin
            nib = sh[4*idx +: 4];
            an  = ~(8'h01 << idx);
            sg  = DEC[nib];
            dp  = ~shdp[idx];
`ifdef SEG7_LZB_EN
            if ((idx >= 1) && ((sh >> (4 * idx)) == 32'd0) && !shdp[idx]) begin
                an = 8'hFF;
                sg = 7'h7F;
                dp = 1'b1;
            end
`endif
        end
        return {an, sg, dp, tk};
    endfunction

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    // One clock: push the expectations for this edge, then step off the edge
    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp1_q.push_back(EXP_DARK);
            exp2_q.push_back(EXP_DARK);
            k1 = 0; k2 = 0;
            sh1 = '0; sh2 = '0;
            shdp1 = '0; shdp2 = '0;
        end else begin
            k1++;
            k2++;
            exp1_q.push_back(expect_out(k1, 4, 1, sh1, shdp1));
            exp2_q.push_back(expect_out(k2, 2, 0, sh2, shdp2));
            // A latch at this edge is visible from the next edge on
            if ((k1 % 32) == 0) begin sh1 = seg_data; shdp1 = dp_mask; end
            if ((k2 % 16) == 0) begin sh2 = seg_data; shdp2 = dp_mask; end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until dut1's scan position after the last edge is digit `idx`
    task automatic run_until_idx(input int idx);
        int guard;
        guard = 0;
        while ((((k1 / 4) % 8) != idx) && (guard < 64)) begin
            step();
            guard++;
        end
        n_checks++;
        if (((k1 / 4) % 8) != idx) begin
            n_fail++;
            $display("FAIL seek_idx: got idx %0d, required %0d", (k1 / 4) % 8, idx);
        end
    endtask

    // Advance until dut1 is `ph` cycles into its current frame
    task automatic run_until_phase(input int ph);
        int guard;
        guard = 0;
        while (((k1 % 32) != ph) && (guard < 64)) begin
            step();
            guard++;
        end
        n_checks++;
        if ((k1 % 32) != ph) begin
            n_fail++;
            $display("FAIL seek_phase: got phase %0d, required %0d", k1 % 32, ph);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compare on the falling edge, away from the active edge
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        logic [16:0] e, g;
        if (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            g = {an1_n, seg1_n, dp1_n, tick1};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL dut1_out k=%0d: got an=%h seg=%h dp=%b tick=%b, required an=%h seg=%h dp=%b tick=%b",
                         k1, g[16:9], g[8:2], g[1], g[0], e[16:9], e[8:2], e[1], e[0]);
            end
        end
        if (exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            g = {an2_n, seg2_n, dp2_n, tick2};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL dut2_out k=%0d: got an=%h seg=%h dp=%b tick=%b, required an=%h seg=%h dp=%b tick=%b",
                         k2, g[16:9], g[8:2], g[1], g[0], e[16:9], e[8:2], e[1], e[0]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        seg_data = '0;
        dp_mask  = '0;
        k1 = 0; k2 = 0;
        sh1 = '0; sh2 = '0;
        shdp1 = '0; shdp2 = '0;

        // Reset held for two cycles: display dark, no strobe
        run(2);
        rst = 1'b0;

        // First frame shows zeros, then 12345678 after the first strobe
        seg_data = 32'h12345678;
        run(70);

        // Reset in digit 5's slot with a non-zero shadow: dark, restart at digit 0 showing 0
        run_until_idx(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(40);

        // Mid-frame change: old value stays up until the next strobe
        run_until_phase(16);
        seg_data = 32'hFFFFFFFF;
        run(80);

        // Decimal point only on digit 0
        dp_mask = 8'h01;
        run(64);

        // Leading zeros, without and with a decimal point on digit 3
        seg_data = 32'h000000A5;
        dp_mask  = 8'h00;
        run(64);
        dp_mask = 8'h08;
        run(64);

        // Remaining decode entries and a mixed decimal-point pattern
        seg_data = 32'h9BCDE0F7;
        dp_mask  = 8'hA5;
        run(64);

        // All zero: only digit 0 survives leading-zero blanking
        seg_data = 32'h00000000;
        dp_mask  = 8'h00;
        run(64);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && ((exp1_q.size() > 0) || (exp2_q.size() > 0)); i++) begin
            @(negedge clk);
        end
        #1;
        n_checks++;
        if ((exp1_q.size() > 0) || (exp2_q.size() > 0)) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d entries left, required 0/0", exp1_q.size(), exp2_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
